du_ctrl: RTL



---
 rtl/du_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/du_ctrl.sv
// Sequencing FSM for the 4x4 shift-add multiplier datapath: LOAD, then one shift/add per cycle, then DONE.
// Define DU_CTRL_EARLY_EXIT_EN to leave CALC as soon as the B register reaches zero.
module du_ctrl #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          b0,
  input  logic          z,
  output logic          ldA,
  output logic          ctrlA,
  output logic          ldB,
  output logic          ctrlB,
  output logic          Psel,
  output logic          ldP,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          calc_exit;

`ifdef DU_CTRL_EARLY_EXIT_EN
  assign calc_exit = (cnt == CNT_MAX) || z;
`else
  // z stays on the port so both builds share one footprint.
  logic unused_z;
  assign unused_z  = z;
  assign calc_exit = (cnt == CNT_MAX);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ldA       = 1'b0;
    ctrlA     = 1'b0;
    ldB       = 1'b0;
    ctrlB     = 1'b0;
    Psel      = 1'b0;
    ldP       = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        ldA       = 1'b1;
        ctrlA     = 1'b1;
        ldB       = 1'b1;
        ctrlB     = 1'b1;
        ldP       = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        if (calc_exit) begin
          state_nxt = DONE;
        end else begin
          // P accumulates the pre-shift A whenever the current multiplier LSB is set.
          ldA     = 1'b1;
          ldB     = 1'b1;
          Psel    = 1'b1;
          ldP     = b0;
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign iter = cnt;

endmodule
